// File: rtl/scr1_dmem_arb2_if.sv
// DMEM req/req_ack/resp bundle: master drives the request fields, slave returns ack, read data and response.
// Combinational on both sides; the bundle holds no state and applies no backpressure of its own.
interface scr1_dmem_arb2_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    logic              req;
    logic              cmd;
    logic [1:0]        width;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
    logic              req_ack;
    logic [DWIDTH-1:0] rdata;
    logic [1:0]        resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );
endinterface

// File: rtl/scr1_dmem_arb2.sv
// Round-robin 2:1 arbiter giving the LSU (m0) and a secondary master (m1) one DMEM port, one transaction in flight.
// Zero-cycle req/ack and resp paths; a presented request keeps its grant until DMEM acks it or it is withdrawn.
module scr1_dmem_arb2 #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    scr1_dmem_arb2_if.slave   m0_if,
    scr1_dmem_arb2_if.slave   m1_if,
    scr1_dmem_arb2_if.master  dmem_if
);
    localparam logic [1:0] RESP_IDLE   = 2'd0;
    localparam logic [1:0] RESP_RDY_OK = 2'd1;
    localparam logic [1:0] RESP_RDY_ER = 2'd2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_owner;
    logic   w_owner_nxt;
    logic   r_rr_ptr;
    logic   w_rr_ptr_nxt;
    logic   r_lock;
    logic   w_lock_nxt;
    logic   r_lock_port;
    logic   w_lock_port_nxt;

    logic              w_sel;
    logic              w_sel_req;
    logic              w_sel_cmd;
    logic [1:0]        w_sel_width;
    logic [AWIDTH-1:0] w_sel_addr;
    logic [DWIDTH-1:0] w_sel_wdata;
    logic              w_resp_done;

    // A locked grant overrides fairness so a waiting request never sees its address change under it.
    always_comb begin
        w_sel = r_rr_ptr;
        if (r_lock) begin
            w_sel = r_lock_port;
        end else if (m0_if.req && !m1_if.req) begin
            w_sel = 1'b0;
        end else if (m1_if.req && !m0_if.req) begin
            w_sel = 1'b1;
        end
    end

    assign w_sel_req   = w_sel ? m1_if.req   : m0_if.req;
    assign w_sel_cmd   = w_sel ? m1_if.cmd   : m0_if.cmd;
    assign w_sel_width = w_sel ? m1_if.width : m0_if.width;
    assign w_sel_addr  = w_sel ? m1_if.addr  : m0_if.addr;
    assign w_sel_wdata = w_sel ? m1_if.wdata : m0_if.wdata;

    // Encoding 3 is not a completion; it is treated as IDLE and never forwarded.
    assign w_resp_done = (dmem_if.resp == RESP_RDY_OK) || (dmem_if.resp == RESP_RDY_ER);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_rr_ptr    <= 1'b0;
            r_lock      <= 1'b0;
            r_lock_port <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_lock      <= w_lock_nxt;
            r_lock_port <= w_lock_port_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_lock_nxt      = r_lock;
        w_lock_port_nxt = r_lock_port;

        dmem_if.req     = 1'b0;
        dmem_if.cmd     = 1'b0;
        dmem_if.width   = 2'd0;
        dmem_if.addr    = '0;
        dmem_if.wdata   = '0;
        m0_if.req_ack   = 1'b0;
        m1_if.req_ack   = 1'b0;
        m0_if.rdata     = '0;
        m1_if.rdata     = '0;
        m0_if.resp      = RESP_IDLE;
        m1_if.resp      = RESP_IDLE;

        case (r_state)
            ST_IDLE: begin
                dmem_if.req   = w_sel_req;
                dmem_if.cmd   = w_sel_cmd;
                dmem_if.width = w_sel_width;
                dmem_if.addr  = w_sel_addr;
                dmem_if.wdata = w_sel_wdata;
                if (w_sel) begin
                    m1_if.req_ack = dmem_if.req_ack;
                end else begin
                    m0_if.req_ack = dmem_if.req_ack;
                end

                if (w_sel_req && dmem_if.req_ack) begin
                    w_state_nxt  = ST_BUSY;
                    w_owner_nxt  = w_sel;
                    w_rr_ptr_nxt = ~w_sel;
                    w_lock_nxt   = 1'b0;
                end else if (w_sel_req) begin
                    w_lock_nxt      = 1'b1;
                    w_lock_port_nxt = w_sel;
                end else begin
                    // Locked requester withdrew: release so the other port can win next cycle.
                    w_lock_nxt = 1'b0;
                end
            end

            ST_BUSY: begin
                m0_if.rdata = dmem_if.rdata;
                m1_if.rdata = dmem_if.rdata;
                if (w_resp_done) begin
                    if (r_owner) begin
                        m1_if.resp = dmem_if.resp;
                    end else begin
                        m0_if.resp = dmem_if.resp;
                    end
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_scr1_dmem_arb2.sv
// Bench for scr1_dmem_arb2: directed scenarios plus a randomized run against a transaction-level reference model.
module tb_scr1_dmem_arb2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    scr1_dmem_arb2_if #(.AWIDTH(AW), .DWIDTH(DW)) m0_if ();
    scr1_dmem_arb2_if #(.AWIDTH(AW), .DWIDTH(DW)) m1_if ();
    scr1_dmem_arb2_if #(.AWIDTH(AW), .DWIDTH(DW)) dm_if ();

    scr1_dmem_arb2 #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_if   (m0_if),
        .m1_if   (m1_if),
        .dmem_if (dm_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who is being served, who wins a tie, and which presented request is still waiting.
    int md_busy  = 0;
    int md_owner = 0;
    int md_pref  = 0;
    int md_stuck = -1;
    int md_w;
    logic md_rq;

    logic        e_dreq, e_dcmd;
    logic [1:0]  e_dw;
    logic [31:0] e_da, e_dd;
    logic [1:0]  e_ack;
    logic [1:0]  e_resp0, e_resp1;
    logic [31:0] e_rd0, e_rd1;

    function automatic int pick();
        if (md_stuck >= 0) return md_stuck;
        if (m0_if.req && !m1_if.req) return 0;
        if (m1_if.req && !m0_if.req) return 1;
        return md_pref;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            md_busy = 0; md_owner = 0; md_pref = 0; md_stuck = -1;
        end else if (md_busy == 0) begin
            md_w  = pick();
            md_rq = (md_w == 1) ? m1_if.req : m0_if.req;
            if (md_rq && dm_if.req_ack) begin
                md_busy = 1; md_owner = md_w; md_pref = 1 - md_w; md_stuck = -1;
            end else if (md_rq) begin
                md_stuck = md_w;
            end else begin
                md_stuck = -1;
            end
        end else if (dm_if.resp == 2'd1 || dm_if.resp == 2'd2) begin
            md_busy = 0;
        end
    end

    task automatic model_eval();
        int w;
        e_dreq = 0; e_dcmd = 0; e_dw = 0; e_da = 0; e_dd = 0; e_ack = 0;
        e_resp0 = 0; e_resp1 = 0; e_rd0 = 0; e_rd1 = 0;
        if (md_busy == 0) begin
            w = pick();
            if (w == 1) begin
                e_dreq = m1_if.req; e_dcmd = m1_if.cmd; e_dw = m1_if.width;
                e_da = m1_if.addr; e_dd = m1_if.wdata; e_ack = {dm_if.req_ack, 1'b0};
            end else begin
                e_dreq = m0_if.req; e_dcmd = m0_if.cmd; e_dw = m0_if.width;
                e_da = m0_if.addr; e_dd = m0_if.wdata; e_ack = {1'b0, dm_if.req_ack};
            end
        end else begin
            e_rd0 = dm_if.rdata;
            e_rd1 = dm_if.rdata;
            if (dm_if.resp == 2'd1 || dm_if.resp == 2'd2) begin
                if (md_owner == 1) e_resp1 = dm_if.resp;
                else               e_resp0 = dm_if.resp;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic req, input logic cmd,
                            input logic [1:0] w, input logic [31:0] a, input logic [31:0] d);
        if (p == 1) begin
            m1_if.req = req; m1_if.cmd = cmd; m1_if.width = w; m1_if.addr = a; m1_if.wdata = d;
        end else begin
            m0_if.req = req; m0_if.cmd = cmd; m0_if.width = w; m0_if.addr = a; m0_if.wdata = d;
        end
    endtask

    task automatic set_dmem(input logic ack, input logic [1:0] resp, input logic [31:0] rd);
        dm_if.req_ack = ack; dm_if.resp = resp; dm_if.rdata = rd;
    endtask

    task automatic clear_inputs();
        set_port(0, 0, 0, 2'd0, 32'h0, 32'h0);
        set_port(1, 0, 0, 2'd0, 32'h0, 32'h0);
        set_dmem(0, 2'd0, 32'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        step();
        @(negedge clk);
        n_cmp++; if (dm_if.req !== 1'b0) begin n_bad++; $display("FAIL reset_dmem_req got %0b want 0", dm_if.req); end
        n_cmp++; if ({m1_if.req_ack, m0_if.req_ack} !== 2'b00) begin n_bad++; $display("FAIL reset_acks got %b want 00", {m1_if.req_ack, m0_if.req_ack}); end
        n_cmp++; if ({m0_if.resp, m1_if.resp} !== 4'h0) begin n_bad++; $display("FAIL reset_resp got %h want 0", {m0_if.resp, m1_if.resp}); end
        n_cmp++; if (dm_if.addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr got %h want 0", dm_if.addr); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        set_port(0, 1, 0, 2'd2, 32'h100, 32'h0);
        set_dmem(1, 2'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if (dm_if.req !== 1'b1 || dm_if.addr !== 32'h100) begin n_bad++; $display("FAIL rd_fwd got req=%0b addr=%h want 1/100", dm_if.req, dm_if.addr); end
        n_cmp++; if ({m1_if.req_ack, m0_if.req_ack} !== 2'b01) begin n_bad++; $display("FAIL rd_ack got %b want 01", {m1_if.req_ack, m0_if.req_ack}); end
        step();
        set_port(0, 0, 0, 2'd0, 32'h0, 32'h0);
        set_dmem(0, 2'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if (m0_if.resp !== 2'd0 || dm_if.req !== 1'b0) begin n_bad++; $display("FAIL rd_wait got resp=%0d req=%0b want 0/0", m0_if.resp, dm_if.req); end
        step();
        set_dmem(0, 2'd1, 32'hDEADBEEF);
        @(negedge clk);
        n_cmp++; if (m0_if.resp !== 2'd1 || m0_if.rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_resp got %0d/%h want 1/deadbeef", m0_if.resp, m0_if.rdata); end
        n_cmp++; if (m1_if.resp !== 2'd0) begin n_bad++; $display("FAIL rd_m1_resp got %0d want 0", m1_if.resp); end
        step();
        set_dmem(0, 2'd0, 32'h0);
    endtask

    task automatic test_round_robin();
        int cnt0 = 0;
        int cnt1 = 0;
        do_reset();
        set_port(0, 1, 0, 2'd2, 32'h1000, 32'h0);
        set_port(1, 1, 0, 2'd2, 32'h2000, 32'h0);
        for (int i = 0; i < 8; i++) begin
            set_dmem(1, 2'd0, 32'h0);
            @(negedge clk);
            if (m0_if.req_ack === 1'b1) cnt0++;
            if (m1_if.req_ack === 1'b1) cnt1++;
            n_cmp++; if ({m1_if.req_ack, m0_if.req_ack} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL rr_grant%0d got %b want %b", i, {m1_if.req_ack, m0_if.req_ack}, (i % 2 == 1) ? 2'b10 : 2'b01); end
            n_cmp++; if (dm_if.addr !== ((i % 2 == 1) ? 32'h2000 : 32'h1000)) begin n_bad++; $display("FAIL rr_addr%0d got %h", i, dm_if.addr); end
            step();
            set_dmem(1, 2'd1, i);
            @(negedge clk);
            n_cmp++; if ({m1_if.resp, m0_if.resp} !== ((i % 2 == 1) ? 4'b0100 : 4'b0001)) begin n_bad++; $display("FAIL rr_resp%0d got %b", i, {m1_if.resp, m0_if.resp}); end
            step();
        end
        n_cmp++; if (cnt0 != 4 || cnt1 != 4) begin n_bad++; $display("FAIL rr_counts got %0d/%0d want 4/4", cnt0, cnt1); end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        set_port(0, 1, 0, 2'd2, 32'h3000, 32'h0);
        set_port(1, 1, 1, 2'd2, 32'h4000, 32'h5);
        set_dmem(0, 2'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            if (k == 3) set_dmem(1, 2'd0, 32'h0);
            @(negedge clk);
            n_cmp++; if (dm_if.addr !== 32'h3000 || m1_if.req_ack !== 1'b0) begin n_bad++; $display("FAIL lock_hold%0d got addr=%h m1ack=%0b", k, dm_if.addr, m1_if.req_ack); end
            step();
        end
        set_port(0, 0, 0, 2'd0, 32'h0, 32'h0);
        set_dmem(1, 2'd1, 32'h77);
        @(negedge clk);
        n_cmp++; if (m0_if.resp !== 2'd1 || m1_if.req_ack !== 1'b0) begin n_bad++; $display("FAIL lock_m0resp got resp=%0d m1ack=%0b", m0_if.resp, m1_if.req_ack); end
        step();
        set_dmem(1, 2'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if (dm_if.addr !== 32'h4000 || m1_if.req_ack !== 1'b1) begin n_bad++; $display("FAIL lock_m1grant got addr=%h ack=%0b", dm_if.addr, m1_if.req_ack); end
        step();
        set_port(1, 0, 0, 2'd0, 32'h0, 32'h0);
        set_dmem(0, 2'd1, 32'h0);
        step();
        clear_inputs();
    endtask

    task automatic test_error();
        do_reset();
        set_port(1, 1, 1, 2'd2, 32'h300, 32'h12345678);
        set_dmem(1, 2'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if (dm_if.cmd !== 1'b1 || dm_if.wdata !== 32'h12345678 || m1_if.req_ack !== 1'b1) begin n_bad++; $display("FAIL err_fwd got cmd=%0b wd=%h ack=%0b", dm_if.cmd, dm_if.wdata, m1_if.req_ack); end
        step();
        set_port(1, 0, 0, 2'd0, 32'h0, 32'h0);
        set_dmem(0, 2'd2, 32'h0);
        @(negedge clk);
        n_cmp++; if (m1_if.resp !== 2'd2 || m0_if.resp !== 2'd0) begin n_bad++; $display("FAIL err_resp got m1=%0d m0=%0d want 2/0", m1_if.resp, m0_if.resp); end
        step();
        set_port(0, 1, 0, 2'd0, 32'h500, 32'h0);
        set_dmem(1, 2'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if (m1_if.resp !== 2'd0 || dm_if.req !== 1'b1 || m0_if.req_ack !== 1'b1) begin n_bad++; $display("FAIL err_after got m1resp=%0d req=%0b m0ack=%0b", m1_if.resp, dm_if.req, m0_if.req_ack); end
        step();
        set_port(0, 0, 0, 2'd0, 32'h0, 32'h0);
        set_dmem(0, 2'd1, 32'h0);
        step();
        clear_inputs();
    endtask

    task automatic test_reset_busy();
        do_reset();
        set_port(0, 1, 0, 2'd2, 32'h600, 32'h0);
        set_dmem(1, 2'd0, 32'h0);
        step();
        set_port(0, 0, 0, 2'd0, 32'h0, 32'h0);
        set_dmem(0, 2'd0, 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_port(1, 1, 0, 2'd2, 32'h700, 32'h0);
        set_dmem(0, 2'd1, 32'hCAFE);
        @(negedge clk);
        n_cmp++; if ({m1_if.resp, m0_if.resp} !== 4'h0) begin n_bad++; $display("FAIL rstbusy_resp got %b want 0000", {m1_if.resp, m0_if.resp}); end
        n_cmp++; if (dm_if.req !== 1'b1 || dm_if.addr !== 32'h700) begin n_bad++; $display("FAIL rstbusy_req got %0b/%h want 1/700", dm_if.req, dm_if.addr); end
        step();
        set_dmem(1, 2'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if (m1_if.req_ack !== 1'b1) begin n_bad++; $display("FAIL rstbusy_ack got %0b want 1", m1_if.req_ack); end
        step();
        set_port(1, 0, 0, 2'd0, 32'h0, 32'h0);
        set_dmem(0, 2'd1, 32'h0);
        step();
        clear_inputs();
    endtask

    task automatic test_abandon();
        do_reset();
        set_port(1, 1, 0, 2'd2, 32'h800, 32'h0);
        set_dmem(0, 2'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if (dm_if.req !== 1'b1 || dm_if.addr !== 32'h800) begin n_bad++; $display("FAIL abn_first got %0b/%h want 1/800", dm_if.req, dm_if.addr); end
        step();
        set_port(1, 0, 0, 2'd0, 32'h0, 32'h0);
        set_port(0, 1, 0, 2'd2, 32'h900, 32'h0);
        @(negedge clk);
        n_cmp++; if (dm_if.req !== 1'b0 || m0_if.req_ack !== 1'b0) begin n_bad++; $display("FAIL abn_drop got req=%0b m0ack=%0b want 0/0", dm_if.req, m0_if.req_ack); end
        step();
        set_dmem(1, 2'd0, 32'h0);
        @(negedge clk);
        n_cmp++; if (dm_if.addr !== 32'h900 || m0_if.req_ack !== 1'b1) begin n_bad++; $display("FAIL abn_m0 got addr=%h ack=%0b want 900/1", dm_if.addr, m0_if.req_ack); end
        step();
        set_port(0, 0, 0, 2'd0, 32'h0, 32'h0);
        set_dmem(0, 2'd1, 32'h0);
        step();
        clear_inputs();
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            set_port(0, ($urandom_range(0, 2) != 0), $urandom_range(0, 1), $urandom_range(0, 2), $urandom, $urandom);
            set_port(1, ($urandom_range(0, 2) != 0), $urandom_range(0, 1), $urandom_range(0, 2), $urandom, $urandom);
            r = $urandom_range(0, 7);
            set_dmem($urandom_range(0, 1), (r < 4) ? 2'd0 : 2'(r - 4), $urandom);
            @(negedge clk);
            model_eval();
            n_cmp++; if ({dm_if.req, dm_if.cmd, dm_if.width, dm_if.addr, dm_if.wdata} !== {e_dreq, e_dcmd, e_dw, e_da, e_dd}) begin
                n_bad++; $display("FAIL rnd_dmem c=%0d got %0b/%0b/%0d/%h/%h want %0b/%0b/%0d/%h/%h", c,
                    dm_if.req, dm_if.cmd, dm_if.width, dm_if.addr, dm_if.wdata, e_dreq, e_dcmd, e_dw, e_da, e_dd); end
            n_cmp++; if ({m1_if.req_ack, m0_if.req_ack} !== e_ack) begin n_bad++; $display("FAIL rnd_ack c=%0d got %b want %b", c, {m1_if.req_ack, m0_if.req_ack}, e_ack); end
            n_cmp++; if ({m0_if.resp, m1_if.resp} !== {e_resp0, e_resp1}) begin n_bad++; $display("FAIL rnd_resp c=%0d got %0d/%0d want %0d/%0d", c, m0_if.resp, m1_if.resp, e_resp0, e_resp1); end
            n_cmp++; if ({m0_if.rdata, m1_if.rdata} !== {e_rd0, e_rd1}) begin n_bad++; $display("FAIL rnd_rdata c=%0d got %h/%h want %h/%h", c, m0_if.rdata, m1_if.rdata, e_rd0, e_rd1); end
            step();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_error();
        test_reset_busy();
        test_abandon();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
